// File: rtl/round_constant_inv_gen_pkg.sv
// Shared uBlock round-constant definitions: LFSR forward/inverse steps, constant mapping,
// seed and generator FSM encoding.
package round_constant_inv_gen_pkg;

  localparam logic [7:0] RC_SEED = 8'h6C;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StReady
  } rc_state_e;

  // f(q): one forward LFSR step
  function automatic logic [7:0] rc_fwd_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[6] ^ q[2] ^ q[1]};
  endfunction

  // g(s): exact inverse of rc_fwd_step, recovers the bit shifted out at the top
  function automatic logic [7:0] rc_inv_step(input logic [7:0] s);
    return {s[0] ^ s[7] ^ s[3] ^ s[2], s[7:1]};
  endfunction

  // M(d): expand one LFSR byte into the 32-bit round constant
  function automatic logic [31:0] rc_map(input logic [7:0] d);
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] p0;
    p3 = {d[7], ~d[6], d[5:0]};
    p2 = {d[7], ~d[6], d[5], ~d[4], d[3], ~d[2], d[1:0]};
    p1 = {d[7:5], ~d[4], d[3:1], ~d[0]};
    p0 = {d[7:3], ~d[2], d[1], ~d[0]};
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/round_constant_inv_gen.sv
// Decryption-side round-constant generator: warms the LFSR up to the final round, then
// steps it backwards so constants come out from round ROUNDS-1 down to round 0.
module round_constant_inv_gen
  import round_constant_inv_gen_pkg::*;
#(
  parameter int unsigned ROUNDS = 16,
  parameter logic [7:0]  SEED   = RC_SEED,
  parameter int unsigned IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             round_cnt,
  output logic             busy,
  output logic             rc_valid,
  output logic [IDX_W-1:0] rc_idx,
  output logic             last,
  output logic [31:0]      round_constant
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] One     = IDX_W'(1);

  rc_state_e        state_q;
  logic [7:0]       lfsr_q;
  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      lfsr_q   <= 8'h00;
      cnt_q    <= '0;
      rc_idx   <= '0;
      busy     <= 1'b0;
      rc_valid <= 1'b0;
      last     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StWarmup;
            lfsr_q  <= SEED;
            cnt_q   <= LastIdx;
            busy    <= 1'b1;
          end
        end
        StWarmup: begin
          lfsr_q <= rc_fwd_step(lfsr_q);
          cnt_q  <= cnt_q - One;
          if (cnt_q == One) begin
            state_q  <= StReady;
            rc_idx   <= LastIdx;
            busy     <= 1'b0;
            rc_valid <= 1'b1;
            last     <= 1'b0;
          end
        end
        StReady: begin
          // A restart takes priority over a pending backward step
          if (start) begin
            state_q  <= StWarmup;
            lfsr_q   <= SEED;
            cnt_q    <= LastIdx;
            busy     <= 1'b1;
            rc_valid <= 1'b0;
            last     <= 1'b0;
          end else if (round_cnt) begin
            if (rc_idx != '0) begin
              lfsr_q <= rc_inv_step(lfsr_q);
              rc_idx <= rc_idx - One;
              last   <= (rc_idx == One);
            end else begin
              state_q  <= StIdle;
              rc_valid <= 1'b0;
              last     <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Constant for the round held in lfsr_q is M(f(q)); gated so nothing leaks while invalid
  assign round_constant = rc_valid ? rc_map(rc_fwd_step(lfsr_q)) : 32'h0;

endmodule

// File: tb/tb_round_constant_inv_gen.sv
// Directed bench for round_constant_inv_gen: ROUNDS=16 and ROUNDS=24 instances against a
// forward-only golden table built from an independent XOR-mask formulation of the constant.
module tb_round_constant_inv_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start     [2];
  logic        round_cnt [2];
  logic        busy      [2];
  logic        rc_valid  [2];
  logic        last      [2];
  logic [4:0]  rc_idx    [2];
  logic [31:0] rc        [2];
  logic [31:0] gold      [24];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  round_constant_inv_gen #(.ROUNDS(16), .SEED(8'h6C), .IDX_W(5)) u_dut16 (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start[0]),
    .round_cnt     (round_cnt[0]),
    .busy          (busy[0]),
    .rc_valid      (rc_valid[0]),
    .rc_idx        (rc_idx[0]),
    .last          (last[0]),
    .round_constant(rc[0])
  );

  round_constant_inv_gen #(.ROUNDS(24), .SEED(8'h6C), .IDX_W(5)) u_dut24 (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start[1]),
    .round_cnt     (round_cnt[1]),
    .busy          (busy[1]),
    .rc_valid      (rc_valid[1]),
    .rc_idx        (rc_idx[1]),
    .last          (last[1]),
    .round_constant(rc[1])
  );

  function automatic logic [7:0] mdl_fwd(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hC6)};
  endfunction

  // Each byte of the constant is d with a fixed set of bits inverted
  function automatic logic [31:0] mdl_const(input logic [7:0] d);
    return {4{d}} ^ 32'h4054_1105;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "_const"}, rc[u], 32'h0);
    check({tag, "_ctl"}, 32'({busy[u], rc_valid[u], last[u], rc_idx[u]}), 32'h0);
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    step();
    start[u] = 1'b0;
  endtask

  // Counts busy cycles (optionally poking start mid-warmup), then checks the first constant
  task automatic wait_ready(input int u, input int rounds, input int poke);
    int   n;
    logic leak;
    n    = 0;
    leak = 1'b0;
    while (busy[u] === 1'b1 && n < 100) begin
      if (rc[u] !== 32'h0 || rc_valid[u] !== 1'b0) leak = 1'b1;
      if (n == poke) start[u] = 1'b1;
      step();
      start[u] = 1'b0;
      n++;
    end
    check("warmup_len", 32'(n), 32'(rounds - 1));
    check("warmup_quiet", 32'(leak), 32'h0);
    check("ready_valid", 32'(rc_valid[u]), 32'h1);
    check("ready_idx", 32'(rc_idx[u]), 32'(rounds - 1));
    check("ready_const", rc[u], gold[rounds-1]);
  endtask

  task automatic walk(input int u, input int rounds, input bit gapped);
    int gap;
    for (int i = rounds - 1; i >= 0; i--) begin
      check($sformatf("walk_idx%0d", i), 32'(rc_idx[u]), 32'(i));
      check($sformatf("walk_const%0d", i), rc[u], gold[i]);
      check($sformatf("walk_last%0d", i), 32'(last[u]), 32'(i == 0));
      check($sformatf("walk_valid%0d", i), 32'(rc_valid[u]), 32'h1);
      if (i == 1) check("rc1_lit", rc[u], 32'hF0E4A1B5);
      if (i == 0) check("rc0_lit", rc[u], 32'h988CC9DD);
      if (gapped) begin
        gap = $urandom_range(0, 3);
        round_cnt[u] = 1'b0;
        repeat (gap) step();
        check($sformatf("hold_const%0d", i), rc[u], gold[i]);
      end
      round_cnt[u] = 1'b1;
      step();
    end
    round_cnt[u] = 1'b0;
    check("end_valid", 32'(rc_valid[u]), 32'h0);
    check("end_const", rc[u], 32'h0);
    check("end_busy", 32'(busy[u]), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q;
    logic       leak;
    q = 8'h6C;
    for (int i = 0; i < 24; i++) begin
      q       = mdl_fwd(q);
      gold[i] = mdl_const(q);
    end
    for (int u = 0; u < 2; u++) begin
      start[u]     = 1'b0;
      round_cnt[u] = 1'b0;
    end

    step();
    check_idle(0, "in_reset");
    rstn = 1'b1;
    step();
    check_idle(0, "reset16");
    check_idle(1, "reset24");

    leak = 1'b0;
    repeat (50) begin
      step();
      if (rc[0] !== 32'h0 || busy[0] !== 1'b0 || rc_valid[0] !== 1'b0) leak = 1'b1;
    end
    check("idle50", 32'(leak), 32'h0);

    // start in IDLE with round_cnt high: round_cnt must not matter
    round_cnt[0] = 1'b1;
    pulse_start(0);
    round_cnt[0] = 1'b0;
    check("start_busy", 32'(busy[0]), 32'h1);
    wait_ready(0, 16, -1);
    walk(0, 16, 1'b0);

    pulse_start(0);
    wait_ready(0, 16, -1);
    walk(0, 16, 1'b1);

    // Restart from READY at rc_idx=7 with a simultaneous round_cnt; start also poked mid-warmup
    pulse_start(0);
    wait_ready(0, 16, -1);
    round_cnt[0] = 1'b1;
    repeat (8) step();
    check("pre_restart_idx", 32'(rc_idx[0]), 32'd7);
    check("pre_restart_const", rc[0], gold[7]);
    start[0] = 1'b1;
    step();
    start[0]     = 1'b0;
    round_cnt[0] = 1'b0;
    check("restart_busy", 32'(busy[0]), 32'h1);
    check("restart_const", rc[0], 32'h0);
    wait_ready(0, 16, 4);
    walk(0, 16, 1'b0);

    // Asynchronous reset mid-warmup
    pulse_start(0);
    repeat (5) step();
    #2 rstn = 1'b0;
    #1 check_idle(0, "rst_warmup");
    step();
    rstn = 1'b1;
    step();
    check_idle(0, "post_rst_warmup");

    // Asynchronous reset mid-ready
    pulse_start(0);
    wait_ready(0, 16, -1);
    round_cnt[0] = 1'b1;
    repeat (3) step();
    round_cnt[0] = 1'b0;
    check("pre_rst_const", rc[0], gold[12]);
    #2 rstn = 1'b0;
    #1 check_idle(0, "rst_ready");
    step();
    rstn = 1'b1;
    step();
    pulse_start(0);
    wait_ready(0, 16, -1);
    walk(0, 16, 1'b0);

    // ROUNDS=24 instance
    pulse_start(1);
    check("start24_busy", 32'(busy[1]), 32'h1);
    wait_ready(1, 24, -1);
    walk(1, 24, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
